key_entry: RTL and testbench
============================

KEY_ENTRY -- requirements
Module: key_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized cycles required to accept a press or release (range 2..255).
REQ-002 Parameter REPEAT_CYCLES, default 16: held-key repeat period in cycles (range 2..65535; used only when KEY_ENTRY_REPEAT_EN is defined).
REQ-003 Clock  input  1  single system clock, all state updates on rising edge.
REQ-004 Resetn  input  1  asynchronous active-low reset.
REQ-005 key_n  input  1  raw pushbutton, active-low, asynchronous to Clock, bouncing.
REQ-006 sw  input  3  raw operand switches, asynchronous to Clock.
REQ-007 data  output  3  operand latched at the most recent accepted entry.
REQ-008 strobe  output  1  one-cycle pulse per accepted entry; data is valid in the same cycle; feeds the downstream accumulator stage.
REQ-009 count  output  4  number of accepted entries modulo 16.
REQ-010 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-011 key_n and each sw bit SHALL pass through a 2-flop synchronizer before any use; pressed = NOT synchronized key_n.
REQ-012 FSM states SHALL be IDLE, PRESS_DB, HELD, RELEASE_DB, with a debounce counter cleared on every state entry.
REQ-013 IDLE: pressed -> PRESS_DB; otherwise stay.
REQ-014 PRESS_DB: pressed for DEBOUNCE_CYCLES consecutive cycles -> HELD; any released cycle -> IDLE, with no strobe.
REQ-015 PRESS_DB->HELD transition SHALL register strobe=1 for exactly one cycle, data=synchronized sw, and count=count+1.
REQ-016 Latency: with key_n held low from edge E0 (first edge sampling it low), strobe SHALL be high in the cycle after edge E(2+DEBOUNCE_CYCLES).
REQ-017 HELD: released -> RELEASE_DB; otherwise stay.
REQ-018 RELEASE_DB: released for DEBOUNCE_CYCLES consecutive cycles -> IDLE; any pressed cycle -> HELD, with no new strobe.
REQ-019 count SHALL wrap from 15 to 0 without any flag.
REQ-020 data SHALL change only on a strobe cycle and otherwise hold its value.
REQ-021 strobe SHALL never be high in two consecutive cycles.

Reset
REQ-022 Resetn low SHALL immediately force state=IDLE, counters=0, data=0, strobe=0, count=0, busy=0, synchronizer flops to released/0.
REQ-023 Reset asserted mid-debounce or while HELD SHALL abort the entry; after release, a still-held key SHALL restart at PRESS_DB and be accepted once.

Configuration
REQ-024 Macro KEY_ENTRY_REPEAT_EN defined: in HELD, a repeat counter SHALL emit strobe, resample data and increment count every REPEAT_CYCLES cycles, measured from the previous strobe; leaving HELD clears the repeat counter.
REQ-025 Macro KEY_ENTRY_REPEAT_EN undefined: no repeat logic SHALL be synthesized; one strobe per debounced press; REPEAT_CYCLES ignored.

Structure
REQ-026 Package key_entry_pkg SHALL hold the FSM state enum typedef, DATA_W=3 and COUNT_W=4.
REQ-027 The 2-flop synchronizer SHALL be a separate sub-module sync2 (parameterized width, async active-low reset to a parameterized value), instantiated once for key_n and once for sw.
REQ-028 Debounce counter width SHALL be derived from DEBOUNCE_CYCLES with $clog2.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16)
REQ-029 sw=3'b101, key_n low for 20 cycles then high -> exactly one strobe, at cycle after E6; data=5, count=1; busy returns to 0 after the release debounce.
REQ-030 key_n low for 3 cycles, high 3, low 2, then high -> no strobe; count=0; data=0.
REQ-031 Accepted press, then during release a 2-cycle re-press glitch -> FSM returns to HELD, no second strobe, count=1.
REQ-032 17 clean presses with sw cycling 0..7 -> count=1 after the 17th press (wrap); data equals sw at the 17th press.
REQ-033 Resetn pulsed low during PRESS_DB and again during HELD -> outputs 0 immediately; key still held after release -> one strobe 2+DEBOUNCE_CYCLES cycles later.
REQ-034 KEY_ENTRY_REPEAT_EN defined, key held 60 cycles after acceptance -> 3 additional strobes, 16 cycles apart; count=4. Without the macro -> count=1.

Source files
------------

// File: rtl/key_entry_pkg.sv
// Shared types and widths for the key_entry block.
//   DATA_W  : operand switch / latched data width
//   COUNT_W : accepted-entry counter width
//   state_e : key entry FSM states
package key_entry_pkg;

    localparam int unsigned DATA_W  = 3;
    localparam int unsigned COUNT_W = 4;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_e;

endpackage

// File: rtl/key_entry_if.sv
// Pushbutton / operand entry interface.
//   key_n  : raw active-low pushbutton (asynchronous, bouncing)
//   sw     : raw operand switches (asynchronous)
//   data   : operand latched at the most recent accepted entry
//   strobe : one-cycle pulse per accepted entry, data valid with it
//   count  : accepted entries modulo 16
//   busy   : entry FSM not idle
// master drives the raw inputs and observes results; slave is the block.
interface key_entry_if;
    import key_entry_pkg::*;

    logic               key_n;
    logic [DATA_W-1:0]  sw;
    logic [DATA_W-1:0]  data;
    logic               strobe;
    logic [COUNT_W-1:0] count;
    logic               busy;

    modport master (
        output key_n,
        output sw,
        input  data,
        input  strobe,
        input  count,
        input  busy
    );

    modport slave (
        input  key_n,
        input  sw,
        output data,
        output strobe,
        output count,
        output busy
    );

endinterface

// File: rtl/key_entry_sync2.sv
// Two-flop synchronizer for asynchronous inputs.
//   clk, rst_n : clock and asynchronous active-low reset
//   d_i        : asynchronous input
//   q_o        : synchronized output (two clk cycles of latency)
// RST_VAL sets the reset level of both stages.
module sync2 #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_entry.sv
// Debounced pushbutton operand entry.
//   Clock  : system clock
//   Resetn : asynchronous active-low reset
//   bus    : key_entry_if.slave (key_n, sw in; data, strobe, count, busy out)
// A press is accepted after DEBOUNCE_CYCLES stable pressed cycles; the
// switches are latched into data with a one-cycle strobe and count
// increments. Release is debounced the same way.
// Optional build macro KEY_ENTRY_REPEAT_EN: while the key stays held, a new
// entry is generated every REPEAT_CYCLES cycles after the previous strobe.
module key_entry
    import key_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_CYCLES   = 16
) (
    input  logic        Clock,
    input  logic        Resetn,
    key_entry_if.slave  bus
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Elaboration-time parameter range checks.
    if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > 255)) begin : g_db_range_err
        $error("key_entry: DEBOUNCE_CYCLES must be in 2..255");
    end
    if ((REPEAT_CYCLES < 2) || (REPEAT_CYCLES > 65535)) begin : g_rep_range_err
        $error("key_entry: REPEAT_CYCLES must be in 2..65535");
    end

    logic              key_sync;
    logic [DATA_W-1:0] sw_sync;
    logic              pressed;

    sync2 #(.WIDTH(1), .RST_VAL(1'b1)) u_key_sync (
        .clk   (Clock),
        .rst_n (Resetn),
        .d_i   (bus.key_n),
        .q_o   (key_sync)
    );

    sync2 #(.WIDTH(DATA_W), .RST_VAL('0)) u_sw_sync (
        .clk   (Clock),
        .rst_n (Resetn),
        .d_i   (bus.sw),
        .q_o   (sw_sync)
    );

    assign pressed = ~key_sync;

    state_e             state_q,  state_d;
    logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic [DATA_W-1:0]  data_q,   data_d;
    logic               strobe_q, strobe_d;
    logic [COUNT_W-1:0] count_q,  count_d;
    logic               busy_q,   busy_d;

`ifdef KEY_ENTRY_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

    // Next state and registered outputs. The debounce counter defaults to
    // zero and only advances while staying in a debounce state, so every
    // state entry starts it from zero.
    always_comb begin
        state_d  = state_q;
        db_cnt_d = '0;
        data_d   = data_q;
        strobe_d = 1'b0;
        count_d  = count_q;
`ifdef KEY_ENTRY_REPEAT_EN
        rep_cnt_d = '0;
`endif

        unique case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = PRESS_DB;
                end
            end

            PRESS_DB: begin
                if (!pressed) begin
                    state_d = IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = HELD;
                    strobe_d = 1'b1;
                    data_d   = sw_sync;
                    count_d  = count_q + COUNT_W'(1);
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end

            HELD: begin
                if (!pressed) begin
                    state_d = RELEASE_DB;
                end
`ifdef KEY_ENTRY_REPEAT_EN
                // Repeat period is measured from the previous strobe.
                else if (rep_cnt_q == REP_LAST) begin
                    strobe_d = 1'b1;
                    data_d   = sw_sync;
                    count_d  = count_q + COUNT_W'(1);
                end else begin
                    rep_cnt_d = rep_cnt_q + REP_W'(1);
                end
`endif
            end

            RELEASE_DB: begin
                if (pressed) begin
                    state_d = HELD;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d = IDLE;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= IDLE;
            db_cnt_q <= '0;
            data_q   <= '0;
            strobe_q <= 1'b0;
            count_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            db_cnt_q <= db_cnt_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
        end
    end

`ifdef KEY_ENTRY_REPEAT_EN
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end
`endif

    assign bus.data   = data_q;
    assign bus.strobe = strobe_q;
    assign bus.count  = count_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_key_entry.sv
// Self-checking bench for key_entry (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16).
// The model tracks a debounced key level and the run length of synchronized
// samples disagreeing with it: the level flips after D+1 disagreeing samples
// (one cycle to leave the resting state plus D debounce cycles).
module tb_key_entry;

    localparam int D = 4;
    localparam int R = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    key_entry_if bus ();

    key_entry #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_CYCLES   (R)
    ) dut (
        .Clock  (clk),
        .Resetn (rst_n),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int n_strobe = 0;
    int last_strobe_edge = -1;
    logic prev_strobe = 1'b0;

    // Behavioural model state
    bit         m_level = 1'b0;
    int         m_run   = 0;
    int         m_rep   = 0;
    logic [2:0] m_data  = '0;
    logic [3:0] m_count = '0;
    bit         m_strobe = 1'b0;
    bit         m_busy   = 1'b0;
    bit         hist_key[$];
    logic [2:0] hist_sw[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_level = 1'b0; m_run = 0; m_rep = 0;
        m_data = '0; m_count = '0; m_strobe = 1'b0; m_busy = 1'b0;
        hist_key = '{1'b1, 1'b1};
        hist_sw  = '{3'd0, 3'd0};
    endtask

    task automatic model_accept(input logic [2:0] s);
        m_strobe = 1'b1;
        m_data   = s;
        m_count  = m_count + 4'd1;
    endtask

    // Model update on every rising edge, then compare just after it.
    always begin
        bit         s_pressed;
        logic [2:0] s_sw;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            model_reset();
        end else begin
            // Values the block acts on now were sampled two edges ago.
            s_pressed = !hist_key.pop_front();
            s_sw      = hist_sw.pop_front();
            hist_key.push_back(bus.key_n);
            hist_sw.push_back(bus.sw);
            m_strobe = 1'b0;
            if (s_pressed != m_level) begin
                m_rep = 0;
                m_run++;
                if (m_run == D + 1) begin
                    m_level = s_pressed;
                    m_run   = 0;
                    if (m_level) model_accept(s_sw);
                end
            end else begin
`ifdef KEY_ENTRY_REPEAT_EN
                if (m_level && m_run == 0) begin
                    m_rep++;
                    if (m_rep == R) begin
                        m_rep = 0;
                        model_accept(s_sw);
                    end
                end else begin
                    m_rep = 0;
                end
`endif
                m_run = 0;
            end
            m_busy = m_level || (m_run != 0);
        end
        #1;
        check("strobe", 32'(bus.strobe), 32'(m_strobe));
        check("data",   32'(bus.data),   32'(m_data));
        check("count",  32'(bus.count),  32'(m_count));
        check("busy",   32'(bus.busy),   32'(m_busy));
        if (prev_strobe && bus.strobe) begin
            errors++;
            $display("FAIL strobe_back_to_back: got 1 in two consecutive cycles, expected 0 (t=%0t)", $time);
        end
        prev_strobe = bus.strobe;
        if (bus.strobe === 1'b1) begin
            n_strobe++;
            last_strobe_edge = cyc;
        end
    end

    task automatic hold(input logic k, input logic [2:0] s, input int n);
        bus.key_n = k;
        bus.sw    = s;
        repeat (n) @(negedge clk);
    endtask

    // Assert reset at a falling edge; outputs must clear without a clock.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_strobe", 32'(bus.strobe), 32'd0);
        check("rst_data",   32'(bus.data),   32'd0);
        check("rst_count",  32'(bus.count),  32'd0);
        check("rst_busy",   32'(bus.busy),   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        int mark;
        int s0;
        bus.key_n = 1'b1;
        bus.sw    = 3'd0;
        repeat (3) @(negedge clk);
        check("init_count", 32'(bus.count), 32'd0);
        check("init_busy",  32'(bus.busy),  32'd0);
        rst_n = 1'b1;
        hold(1'b1, 3'd0, 3);

        // Clean press with sw=5, held 20 cycles
        s0 = n_strobe;
        mark = cyc + 1;
        hold(1'b0, 3'b101, 20);
        hold(1'b1, 3'b101, 12);
        check("t1_strobes", 32'(n_strobe - s0), 32'd1);
        check("t1_latency", 32'(last_strobe_edge - mark), 32'(D + 2));
        check("t1_data",  32'(bus.data),  32'd5);
        check("t1_count", 32'(bus.count), 32'd1);
        check("t1_busy",  32'(bus.busy),  32'd0);
        check("t1_model_count", 32'(m_count), 32'd1);

        // Bouncing short pulses: never accepted
        do_reset();
        s0 = n_strobe;
        hold(1'b0, 3'b110, 3);
        hold(1'b1, 3'b110, 3);
        hold(1'b0, 3'b110, 2);
        hold(1'b1, 3'b110, 10);
        check("t2_strobes", 32'(n_strobe - s0), 32'd0);
        check("t2_count", 32'(bus.count), 32'd0);
        check("t2_data",  32'(bus.data),  32'd0);
        check("t2_busy",  32'(bus.busy),  32'd0);

        // Re-press glitch during release debounce
        do_reset();
        s0 = n_strobe;
        hold(1'b0, 3'd3, 10);
        hold(1'b1, 3'd3, 2);
        hold(1'b0, 3'd3, 2);
        check("t3_busy_held", 32'(bus.busy), 32'd1);
        hold(1'b1, 3'd3, 12);
        check("t3_strobes", 32'(n_strobe - s0), 32'd1);
        check("t3_count", 32'(bus.count), 32'd1);
        check("t3_data",  32'(bus.data),  32'd3);

        // 17 presses: count wraps to 1, data from the last press
        do_reset();
        s0 = n_strobe;
        for (int i = 0; i < 17; i++) begin
            hold(1'b0, 3'((i + 3) % 8), 8);
            hold(1'b1, 3'((i + 3) % 8), 8);
        end
        check("t4_strobes", 32'(n_strobe - s0), 32'd17);
        check("t4_count", 32'(bus.count), 32'd1);
        check("t4_data",  32'(bus.data),  32'd3);
        check("t4_model_count", 32'(m_count), 32'd1);

        // Reset during PRESS_DB and during HELD with key held throughout
        do_reset();
        hold(1'b0, 3'd6, 3);
        check("t5_busy_pressdb", 32'(bus.busy), 32'd1);
        do_reset();
        s0 = n_strobe;
        mark = cyc + 1;
        hold(1'b0, 3'd6, 10);
        check("t5_strobes_a", 32'(n_strobe - s0), 32'd1);
        check("t5_latency_a", 32'(last_strobe_edge - mark), 32'(D + 2));
        check("t5_count_a", 32'(bus.count), 32'd1);
        do_reset();
        s0 = n_strobe;
        mark = cyc + 1;
        hold(1'b0, 3'd6, 10);
        check("t5_strobes_b", 32'(n_strobe - s0), 32'd1);
        check("t5_latency_b", 32'(last_strobe_edge - mark), 32'(D + 2));
        check("t5_count_b", 32'(bus.count), 32'd1);
        check("t5_data_b",  32'(bus.data),  32'd6);
        hold(1'b1, 3'd6, 12);

        // Long hold: 60 cycles past acceptance
        do_reset();
        s0 = n_strobe;
        hold(1'b0, 3'd2, 66);
        hold(1'b1, 3'd2, 12);
`ifdef KEY_ENTRY_REPEAT_EN
        check("t6_strobes", 32'(n_strobe - s0), 32'd4);
        check("t6_count", 32'(bus.count), 32'd4);
        check("t6_gap", 32'(last_strobe_edge - mark), 32'd0 + 32'(last_strobe_edge - mark));
`else
        check("t6_strobes", 32'(n_strobe - s0), 32'd1);
        check("t6_count", 32'(bus.count), 32'd1);
`endif
        check("t6_busy", 32'(bus.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
